// File: rtl/medium_arbiter_if.sv
// Bus bundle for medium_arbiter.
// Carries both requester medium ports (address, write data, read/write pulses,
// returned data, finished pulse), the single-port BRAM port and the sticky
// protocol error flag.
//   slave  : the arbiter side (consumes requests and BRAM read data)
//   master : the environment side (clients plus BRAM)
interface medium_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 1024,
  parameter int unsigned ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] req0_addr_in;
  logic [DATA_WIDTH-1:0] req0_data_in;
  logic                  req0_read_enable_in;
  logic                  req0_write_enable_in;
  logic [DATA_WIDTH-1:0] req0_data_out;
  logic                  req0_finished_out;

  logic [ADDR_WIDTH-1:0] req1_addr_in;
  logic [DATA_WIDTH-1:0] req1_data_in;
  logic                  req1_read_enable_in;
  logic                  req1_write_enable_in;
  logic [DATA_WIDTH-1:0] req1_data_out;
  logic                  req1_finished_out;

  logic [ADDR_WIDTH-1:0] mem_addr_out;
  logic [DATA_WIDTH-1:0] mem_data_out;
  logic                  mem_en_out;
  logic                  mem_we_out;
  logic [DATA_WIDTH-1:0] mem_data_in;

  logic                  error_out;

  modport slave (
    input  req0_addr_in, req0_data_in, req0_read_enable_in, req0_write_enable_in,
    output req0_data_out, req0_finished_out,
    input  req1_addr_in, req1_data_in, req1_read_enable_in, req1_write_enable_in,
    output req1_data_out, req1_finished_out,
    output mem_addr_out, mem_data_out, mem_en_out, mem_we_out,
    input  mem_data_in,
    output error_out
  );

  modport master (
    output req0_addr_in, req0_data_in, req0_read_enable_in, req0_write_enable_in,
    input  req0_data_out, req0_finished_out,
    output req1_addr_in, req1_data_in, req1_read_enable_in, req1_write_enable_in,
    input  req1_data_out, req1_finished_out,
    input  mem_addr_out, mem_data_out, mem_en_out, mem_we_out,
    output mem_data_in,
    input  error_out
  );
endinterface

// File: rtl/medium_arbiter.sv
// Two-requester round-robin arbiter sharing one single-port BRAM.
// Request pulses are latched into one pending slot per requester; accesses are
// serialised through IDLE -> ISSUE -> (WAIT x READ_LATENCY) -> DONE. Each
// requester gets its read data and a one-cycle finished pulse.
// Ports:
//   clk_in  : clock
//   rst_in  : asynchronous active-high reset
//   bus     : medium_arbiter_if.slave (requester ports, BRAM port, error flag)
module medium_arbiter #(
  parameter int unsigned DATA_WIDTH   = 1024,
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic           clk_in,
  input  logic           rst_in,
  medium_arbiter_if.slave bus
);

  localparam int unsigned     CntW    = 3;
  localparam logic [CntW-1:0] CntLast = CntW'(READ_LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e                state_q, state_d;
  logic                  grant_q, grant_d;
  logic                  last_grant_q, last_grant_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [1:0]            slot_valid_q, slot_valid_d;
  logic [1:0]            slot_write_q, slot_write_d;
  logic [ADDR_WIDTH-1:0] slot_addr_q [2];
  logic [ADDR_WIDTH-1:0] slot_addr_d [2];
  logic [DATA_WIDTH-1:0] slot_data_q [2];
  logic [DATA_WIDTH-1:0] slot_data_d [2];
  logic [DATA_WIDTH-1:0] rdata_q [2];
  logic [DATA_WIDTH-1:0] rdata_d [2];
  logic [1:0]            finished_q, finished_d;
  logic                  mem_en_q, mem_en_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
  logic                  error_q, error_d;

  logic [1:0]            req_rd, req_wr, clear;
  logic [ADDR_WIDTH-1:0] req_addr [2];
  logic [DATA_WIDTH-1:0] req_data [2];

  assign req_rd      = {bus.req1_read_enable_in, bus.req0_read_enable_in};
  assign req_wr      = {bus.req1_write_enable_in, bus.req0_write_enable_in};
  assign req_addr[0] = bus.req0_addr_in;
  assign req_addr[1] = bus.req1_addr_in;
  assign req_data[0] = bus.req0_data_in;
  assign req_data[1] = bus.req1_data_in;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    slot_valid_d = slot_valid_q;
    slot_write_d = slot_write_q;
    slot_addr_d  = slot_addr_q;
    slot_data_d  = slot_data_q;
    rdata_d      = rdata_q;
    finished_d   = 2'b00;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    error_d      = error_q;
    clear        = 2'b00;

    unique case (state_q)
      StIdle: begin
        if (|slot_valid_q) begin
          // Tie goes to whoever was not served last; otherwise the lone valid slot.
          grant_d      = (&slot_valid_q) ? ~last_grant_q : slot_valid_q[1];
          last_grant_d = grant_d;
          mem_en_d     = 1'b1;
          mem_we_d     = slot_write_q[grant_d];
          mem_addr_d   = slot_addr_q[grant_d];
          mem_data_d   = slot_data_q[grant_d];
          state_d      = StIssue;
        end
      end
      StIssue: begin
        if (slot_write_q[grant_q]) begin
          finished_d[grant_q] = 1'b1;
          state_d             = StDone;
        end else begin
          cnt_d   = '0;
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q == CntLast) begin
          rdata_d[grant_q]    = bus.mem_data_in;
          finished_d[grant_q] = 1'b1;
          cnt_d               = '0;
          state_d             = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        clear[grant_q] = 1'b1;
        state_d        = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Clear first so a pulse in the DONE cycle reloads the slot (set wins).
    for (int i = 0; i < 2; i++) begin
      if (clear[i]) slot_valid_d[i] = 1'b0;
      if (req_rd[i] || req_wr[i]) begin
        if (slot_valid_d[i]) begin
          error_d = 1'b1;
        end else begin
          slot_valid_d[i] = 1'b1;
          slot_write_d[i] = req_wr[i];  // write wins over a simultaneous read
          slot_addr_d[i]  = req_addr[i];
          slot_data_d[i]  = req_data[i];
        end
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= StIdle;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      slot_valid_q <= 2'b00;
      slot_write_q <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        slot_addr_q[i] <= '0;
        slot_data_q[i] <= '0;
        rdata_q[i]     <= '0;
      end
      finished_q   <= 2'b00;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      slot_valid_q <= slot_valid_d;
      slot_write_q <= slot_write_d;
      slot_addr_q  <= slot_addr_d;
      slot_data_q  <= slot_data_d;
      rdata_q      <= rdata_d;
      finished_q   <= finished_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      error_q      <= error_d;
    end
  end

  assign bus.req0_data_out     = rdata_q[0];
  assign bus.req1_data_out     = rdata_q[1];
  assign bus.req0_finished_out = finished_q[0];
  assign bus.req1_finished_out = finished_q[1];
  assign bus.mem_en_out        = mem_en_q;
  assign bus.mem_we_out        = mem_we_q;
  assign bus.mem_addr_out      = mem_addr_q;
  assign bus.mem_data_out      = mem_data_q;
  assign bus.error_out         = error_q;

endmodule

// File: tb/tb_medium_arbiter.sv
// Self-checking bench for medium_arbiter: behavioural BRAM with READ_LATENCY
// pipeline, table of request vectors, scoreboard queues of expected BRAM issues
// and finished pulses, plus hand-written protocol-violation and reset sequences.
module tb_medium_arbiter;
  localparam int unsigned DW = 64;
  localparam int unsigned AW = 8;
  localparam int unsigned L  = 2;

  typedef struct {
    logic [1:0]    op0;  // bit0 read pulse, bit1 write pulse
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic [1:0]    op1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic          first;
    int            iss0, fin0, iss1, fin1;  // offsets from the pulse cycle
  } vec_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] data;
    int            at;
  } iss_t;

  typedef struct {
    logic          who;
    logic          rd;
    logic [DW-1:0] data;
    int            at;
  } fin_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  medium_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  medium_arbiter #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .READ_LATENCY(L)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus   (bus)
  );

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return {32'hA0A0_0000 | {24'h0, a}, 24'h5A5A5A, a};
  endfunction

  // Behavioural single-port BRAM; read data valid L cycles after the enable.
  logic [DW-1:0] mem  [256];
  logic [DW-1:0] pipe [L];
  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(AW'(i));
    end else if (bus.mem_en_out && bus.mem_we_out) begin
      mem[bus.mem_addr_out] <= bus.mem_data_out;
    end
    pipe[0] <= (bus.mem_en_out && !bus.mem_we_out) ? mem[bus.mem_addr_out] : '0;
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.mem_data_in = pipe[L-1];

  int            n_checks = 0;
  int            n_pass   = 0;
  iss_t          iss_q [$];
  fin_t          fin_q [$];
  logic [DW-1:0] ref_mem  [256];
  logic [DW-1:0] exp_dout [2];
  vec_t          vecs     [9];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic drive(input logic who, input logic [1:0] op, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    if (!who) begin
      bus.req0_read_enable_in  = op[0];
      bus.req0_write_enable_in = op[1];
      bus.req0_addr_in         = a;
      bus.req0_data_in         = d;
    end else begin
      bus.req1_read_enable_in  = op[0];
      bus.req1_write_enable_in = op[1];
      bus.req1_addr_in         = a;
      bus.req1_data_in         = d;
    end
  endtask

  task automatic idle_reqs();
    drive(1'b0, 2'b00, '0, '0);
    drive(1'b1, 2'b00, '0, '0);
  endtask

  task automatic push_exp(input logic who, input logic [1:0] op, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input int iss, input int fin, input int r);
    iss_t ie;
    fin_t fe;
    if (op == 2'b00) return;
    ie.addr = a;
    ie.we   = op[1];
    ie.data = op[1] ? d : '0;
    ie.at   = r + iss;
    iss_q.push_back(ie);
    if (op[1]) ref_mem[a] = d;
    fe.who  = who;
    fe.rd   = !op[1];
    fe.data = op[1] ? '0 : ref_mem[a];
    fe.at   = r + fin;
    fin_q.push_back(fe);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_d0"}, bus.req0_data_out, '0);
    check({tag, "_d1"}, bus.req1_data_out, '0);
    check({tag, "_f0"}, DW'(bus.req0_finished_out), '0);
    check({tag, "_f1"}, DW'(bus.req1_finished_out), '0);
    check({tag, "_addr"}, DW'(bus.mem_addr_out), '0);
    check({tag, "_wdata"}, bus.mem_data_out, '0);
    check({tag, "_en"}, DW'(bus.mem_en_out), '0);
    check({tag, "_we"}, DW'(bus.mem_we_out), '0);
    check({tag, "_err"}, DW'(bus.error_out), '0);
  endtask

  task automatic monitor();
    iss_t ie;
    fin_t fe;
    logic f;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.mem_en_out) begin
          if (iss_q.size() == 0) begin
            check("unexpected_issue", DW'(1), '0);
          end else begin
            ie = iss_q.pop_front();
            check("issue_cycle", DW'(cyc), DW'(ie.at));
            check("issue_addr", DW'(bus.mem_addr_out), DW'(ie.addr));
            check("issue_we", DW'(bus.mem_we_out), DW'(ie.we));
            if (ie.we) check("issue_wdata", bus.mem_data_out, ie.data);
          end
        end else begin
          check("we_outside_issue", DW'(bus.mem_we_out), '0);
        end
        check("finished_exclusive", DW'(bus.req0_finished_out & bus.req1_finished_out), '0);
        for (int i = 0; i < 2; i++) begin
          f = (i == 0) ? bus.req0_finished_out : bus.req1_finished_out;
          if (f) begin
            if (fin_q.size() == 0) begin
              check("unexpected_finished", DW'(i + 1), '0);
            end else begin
              fe = fin_q.pop_front();
              check("finished_who", DW'(i), DW'(fe.who));
              check("finished_cycle", DW'(cyc), DW'(fe.at));
              if (fe.rd) exp_dout[i] = fe.data;
            end
          end
        end
        check("data_out0", bus.req0_data_out, exp_dout[0]);
        check("data_out1", bus.req1_data_out, exp_dout[1]);
      end
    end
  endtask

  task automatic apply_vec(input vec_t v);
    int r;
    @(posedge clk);
    #1;
    r = cyc;
    drive(1'b0, v.op0, v.a0, v.d0);
    drive(1'b1, v.op1, v.a1, v.d1);
    if (!v.first) begin
      push_exp(1'b0, v.op0, v.a0, v.d0, v.iss0, v.fin0, r);
      push_exp(1'b1, v.op1, v.a1, v.d1, v.iss1, v.fin1, r);
    end else begin
      push_exp(1'b1, v.op1, v.a1, v.d1, v.iss1, v.fin1, r);
      push_exp(1'b0, v.op0, v.a0, v.d0, v.iss0, v.fin0, r);
    end
    @(posedge clk);
    #1;
    idle_reqs();
    repeat (12) @(posedge clk);
    #1;
    check("vec_drained", DW'(iss_q.size() + fin_q.size()), '0);
  endtask

  initial begin
    int r;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(AW'(i));
    exp_dout[0] = '0;
    exp_dout[1] = '0;
    //          op0    a0    d0              op1    a1    d1              1st   i0 f0 i1 f1
    vecs[0] = '{2'd1, 8'd5, '0,             2'd0, 8'd0, '0,             1'b0, 2, 5, 0, 0};
    vecs[1] = '{2'd0, 8'd0, '0,             2'd2, 8'd9, 64'hB0B0_1111, 1'b1, 0, 0, 2, 3};
    vecs[2] = '{2'd0, 8'd0, '0,             2'd1, 8'd9, '0,             1'b1, 0, 0, 2, 5};
    vecs[3] = '{2'd1, 8'd1, '0,             2'd1, 8'd2, '0,             1'b0, 2, 5, 7, 10};
    vecs[4] = '{2'd2, 8'd1, 64'hD0D0_2222, 2'd0, 8'd0, '0,             1'b0, 2, 3, 0, 0};
    vecs[5] = '{2'd1, 8'd3, '0,             2'd1, 8'd4, '0,             1'b1, 7, 10, 2, 5};
    vecs[6] = '{2'd3, 8'd6, 64'hC0C0_3333, 2'd0, 8'd0, '0,             1'b0, 2, 3, 0, 0};
    vecs[7] = '{2'd2, 8'd7, 64'hE0E0_4444, 2'd1, 8'd6, '0,             1'b1, 7, 8, 2, 5};
    vecs[8] = '{2'd1, 8'd7, '0,             2'd2, 8'd8, 64'hF0F0_5555, 1'b1, 5, 8, 2, 3};

    idle_reqs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    fork
      monitor();
    join_none

    for (int i = 0; i < 9; i++) apply_vec(vecs[i]);

    // Re-request while pending is dropped and flags error; re-request in DONE is taken.
    @(posedge clk);
    #1;
    r = cyc;
    check("error_before", DW'(bus.error_out), '0);
    drive(1'b0, 2'b01, 8'd5, '0);
    push_exp(1'b0, 2'b01, 8'd5, '0, 2, 5, r);
    @(posedge clk);
    #1;
    drive(1'b0, 2'b01, 8'd3, '0);
    @(posedge clk);
    #1;
    idle_reqs();
    check("error_set", DW'(bus.error_out), DW'(1));
    repeat (3) @(posedge clk);
    #1;
    drive(1'b0, 2'b01, 8'd1, '0);
    push_exp(1'b0, 2'b01, 8'd1, '0, 2, 5, cyc);
    @(posedge clk);
    #1;
    idle_reqs();
    repeat (8) @(posedge clk);
    #1;
    check("error_sticky", DW'(bus.error_out), DW'(1));
    check("viol_drained", DW'(iss_q.size() + fin_q.size()), '0);

    // Reset during WAIT discards the in-flight read.
    @(posedge clk);
    #1;
    r = cyc;
    drive(1'b0, 2'b01, 8'd2, '0);
    push_exp(1'b0, 2'b01, 8'd2, '0, 2, 5, r);
    @(posedge clk);
    #1;
    idle_reqs();
    repeat (2) @(posedge clk);
    #1;
    check("pre_reset_issued", DW'(iss_q.size()), '0);
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    iss_q.delete();
    fin_q.delete();
    exp_dout[0] = '0;
    exp_dout[1] = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    r = cyc;
    drive(1'b0, 2'b01, 8'd5, '0);
    push_exp(1'b0, 2'b01, 8'd5, '0, 2, 5, r);
    @(posedge clk);
    #1;
    idle_reqs();
    repeat (10) @(posedge clk);
    #1;
    check("post_reset_drained", DW'(iss_q.size() + fin_q.size()), '0);
    check("post_reset_data", bus.req0_data_out, init_val(8'd5));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/medium_arbiter.md
# medium_arbiter

Two-requester, round-robin arbiter that shares one single-port BRAM between two pulse-driven memory media clients, for example the cpu's weight port and heap port. It latches one-cycle read/write enable pulses, serialises the resulting accesses onto the BRAM port, and honours the BRAM's fixed read latency. For each client it returns read data plus a one-cycle `finished` pulse, the same medium handshake the cpu already consumes.

## Interface
- `DATA_WIDTH`, 1024: width of one BRAM word.
- `ADDR_WIDTH`, 8: BRAM address width.
- `READ_LATENCY`, 2: cycles from `mem_en_out` (read) to valid `mem_data_in`. Legal range is 1..7.

Ports:
- `clk_in`  in  1  clock.
- `rst_in`  in  1  reset, asynchronous, active-high.
- `req0_addr_in`  in  ADDR_WIDTH  requester 0 address.
- `req0_data_in`  in  DATA_WIDTH  requester 0 write data.
- `req0_read_enable_in`  in  1  one-cycle read request pulse.
- `req0_write_enable_in`  in  1  one-cycle write request pulse.
- `req0_data_out`  out  DATA_WIDTH  last read data returned to requester 0.
- `req0_finished_out`  out  1  one-cycle completion pulse.
- `req1_*`: identical set for requester 1.
- `mem_addr_out`  out  ADDR_WIDTH  BRAM address.
- `mem_data_out`  out  DATA_WIDTH  BRAM write data.
- `mem_en_out`  out  1  BRAM enable.
- `mem_we_out`  out  1  BRAM write enable.
- `mem_data_in`  in  DATA_WIDTH  BRAM read data.
- `error_out`  out  1  sticky protocol-violation flag.

## Operation
- **Pending slot (one per requester).** Holds `valid`, `is_write`, `addr` and `data`.
  - A request pulse loads the slot when it is empty.
  - If read and write enable pulse in the same cycle, the write wins and the read is dropped.
- **Request while pending.** A pulse arriving while the requester's slot is already valid is dropped and sets `error_out`. `error_out` clears only on reset.
- **Release and reload.** A slot clears in its DONE cycle. A new pulse from the same requester in that DONE cycle is accepted, because set wins over clear.
- **FSM states:** IDLE, ISSUE, WAIT, DONE.
  - **IDLE:** if any slot is valid, choose the grant and go to ISSUE. Otherwise stay in IDLE.
  - **ISSUE** (exactly 1 cycle):
    - `mem_en_out`=1.
    - `mem_we_out`=`is_write`.
    - `mem_addr_out` and `mem_data_out` come from the granted slot.
    - Next state is DONE for a write, WAIT for a read.
  - **WAIT:** a counter runs READ_LATENCY cycles. In the final WAIT cycle, `mem_data_in` is registered into the granted requester's `data_out`. Then go to DONE.
  - **DONE** (1 cycle): the granted `reqN_finished_out`=1, the slot is cleared, and the next state is IDLE.
- **Round robin.** `last_grant` resets to 1, so requester 0 wins the first tie.
  - When both slots are valid in IDLE, grant the requester that is not `last_grant`.
  - When only one slot is valid, grant it.
  - `last_grant` updates on every grant.
- **Output hold.**
  - `reqN_data_out` changes only on a read completion for that requester, and holds otherwise (writes do not disturb it).
  - Outside ISSUE: `mem_en_out`=0 and `mem_we_out`=0; `mem_addr_out` and `mem_data_out` hold their last values.
- **Reset** (async, any state including mid-read): FSM goes to IDLE, slots are cleared, the WAIT counter is cleared, and an in-flight read is discarded.

## Timing
- **Reset values:** every output is 0 (`req*_data_out`, `req*_finished_out`, `mem_*_out`, `error_out`).
- **Cycle numbering:** a request pulse is sampled at the end of cycle r, so the slot is valid in r+1 (IDLE sees it).
- **Uncontended read:**
  - ISSUE in r+2.
  - WAIT r+3..r+2+L.
  - DONE in r+3+L.
  - `finished` and the new `data_out` are both visible in r+3+L, i.e. total latency L+3.
- **Uncontended write:** ISSUE in r+2, `finished` in r+3.
- **Contention:** the losing requester is issued only after the winner's DONE plus one IDLE cycle.
  - A read is in flight for 3+L cycles and a write for 3 cycles.
- **Throughput:** at most one BRAM access per 3 cycles (writes) or L+3 cycles (reads).
- **Finished pulse:** `finished` is asserted for exactly one cycle and is never asserted for both requesters in the same cycle.

## Test plan
- **Single read, requester 0.** Preload BRAM[5]=A. Pulse `req0_read_enable_in` with addr 5 in cycle 0, L=2.
  - Expect `mem_en_out`=1, `mem_we_out`=0, addr 5 in cycle 2.
  - Expect `req0_finished_out`=1 and `req0_data_out`=A in cycle 5 only.
- **Single write then read, requester 1.** Pulse a write of B to addr 9, wait for `finished` (cycle 3), then read addr 9.
  - Expect `req1_data_out`=B.
  - Expect `req0_data_out` unchanged.
- **Simultaneous reads.** Requesters 0 and 1 read addrs 1 and 2 in the same cycle after reset.
  - Requester 0 is issued first, in cycle 2, and `finished0` fires in cycle 5.
  - Requester 1 is issued in cycle 7 and `finished1` fires in cycle 10.
  - Repeat with `last_grant`=0: requester 1 now goes first.
- **Read and write enable together.** Both enables pulse in the same cycle.
  - Only a write occurs (`mem_we_out`=1 in ISSUE) and `req0_data_out` is unchanged.
- **Protocol violation.** Requester 0 pulses again while its read is pending.
  - `error_out` rises and stays at 1.
  - Exactly one access and one `finished` pulse occur.
  - A re-request in the DONE cycle is accepted and issued 2 cycles later.
- **Reset mid-read.** Assert `rst_in` during WAIT.
  - All outputs are 0 immediately, with no `finished` pulse.
  - After reset release, a fresh read completes with L+3 latency.
